// File: rtl/game_controller.sv
// Game state sequencer for the runner game: DEAD/GRACE/PLAY flow, BCD score
// and high-score tracking, driven by the per-frame animate tick.
module game_controller #(
  parameter int GRACE_FRAMES     = 120,
  parameter int DEAD_HOLD_FRAMES = 60,
  parameter int SCORE_DIV        = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_animate,
  input  logic        i_collision,
  input  logic        i_start,
  output logic [1:0]  o_game_state,
  output logic [15:0] o_score,
  output logic [15:0] o_high_score,
  output logic        o_new_high
);

  typedef enum logic [1:0] {
    DEAD  = 2'b00,
    GRACE = 2'b01,
    PLAY  = 2'b10
  } state_t;

  localparam logic [7:0] DEAD_HOLD  = 8'(DEAD_HOLD_FRAMES);
  localparam logic [7:0] GRACE_LAST = 8'(GRACE_FRAMES - 1);
  localparam logic [7:0] SCORE_LAST = 8'(SCORE_DIV - 1);

  state_t     state;
  state_t     state_next;
  logic       start_meta;
  logic       start_sync;
  logic       start_prev;
  logic       press;
  logic       collision_q;
  logic       hit;
  logic [7:0] frame_cnt;
  logic [7:0] div_cnt;
  logic       state_change;
  logic       score_tick;
  logic       enter_grace;
  logic       enter_dead;

  function automatic logic [15:0] bcd_inc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (result[4*i +: 4] == 4'd9) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = result[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

  // i_start is asynchronous: two flops for metastability, a third for the edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      start_meta <= i_start;
      start_sync <= start_meta;
      start_prev <= start_sync;
    end
  end

  assign press = start_sync & ~start_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= i_collision;
    end
  end

  assign hit = collision_q && (state == PLAY);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= DEAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DEAD: begin
        if (press && (frame_cnt >= DEAD_HOLD)) begin
          state_next = GRACE;
        end
      end
      GRACE: begin
        if (i_animate && (frame_cnt == GRACE_LAST)) begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (hit) begin
          state_next = DEAD;
        end
      end
      default: state_next = DEAD;
    endcase
  end

  assign state_change = (state_next != state);
  assign enter_grace  = (state == DEAD) && (state_next == GRACE);
  assign enter_dead   = (state == PLAY) && (state_next == DEAD);
  assign score_tick   = (state == PLAY) && !hit && i_animate && (div_cnt == SCORE_LAST);

  // Reset value 255 lets the very first press start a game immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt <= 8'hFF;
    end else if (state_change) begin
      frame_cnt <= 8'h00;
    end else if (i_animate && (frame_cnt != 8'hFF)) begin
      frame_cnt <= frame_cnt + 8'h01;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt <= 8'h00;
    end else if (state != PLAY) begin
      div_cnt <= 8'h00;
    end else if (i_animate && !hit) begin
      div_cnt <= score_tick ? 8'h00 : div_cnt + 8'h01;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_score <= 16'h0000;
    end else if (enter_grace) begin
      o_score <= 16'h0000;
    end else if (score_tick) begin
      o_score <= bcd_inc(o_score);
    end
  end

  // BCD digits are ordered, so a plain binary compare ranks scores correctly
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_high_score <= 16'h0000;
      o_new_high   <= 1'b0;
    end else begin
      o_new_high <= 1'b0;
      if (enter_dead && (o_score > o_high_score)) begin
        o_high_score <= o_score;
        o_new_high   <= 1'b1;
      end
    end
  end

  assign o_game_state = state;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed vector table, hand-written
// corner sequences, then random play against a frame-level reference model.
module tb_game_controller;

  localparam int GRACE_FRAMES     = 120;
  localparam int DEAD_HOLD_FRAMES = 60;
  localparam int SCORE_DIV        = 6;

  logic        i_clk;
  logic        i_rst;
  logic        i_animate;
  logic        i_collision;
  logic        i_start;
  logic [1:0]  o_game_state;
  logic [15:0] o_score;
  logic [15:0] o_high_score;
  logic        o_new_high;

  int checks = 0;
  int errors = 0;

  game_controller #(
    .GRACE_FRAMES    (GRACE_FRAMES),
    .DEAD_HOLD_FRAMES(DEAD_HOLD_FRAMES),
    .SCORE_DIV       (SCORE_DIV)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_animate   (i_animate),
    .i_collision (i_collision),
    .i_start     (i_start),
    .o_game_state(o_game_state),
    .o_score     (o_score),
    .o_high_score(o_high_score),
    .o_new_high  (o_new_high)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference model: game state as plain integers, scores in decimal
  int m_state;
  int m_frames;
  int m_div;
  int m_score;
  int m_high;
  bit m_new_high;
  bit start_hist[3];
  bit coll_hist;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state    = 0;
    m_frames   = 255;
    m_div      = 0;
    m_score    = 0;
    m_high     = 0;
    m_new_high = 0;
    for (int i = 0; i < 3; i++) start_hist[i] = 0;
    coll_hist = 0;
  endtask

  // One clock edge; a press is the start level seen 2 edges ago rising over 3 edges ago
  task automatic model_step();
    bit press_now;
    bit hit_now;
    press_now  = start_hist[1] && !start_hist[2];
    hit_now    = coll_hist && (m_state == 2);
    m_new_high = 0;
    case (m_state)
      0: begin
        if (press_now && (m_frames >= DEAD_HOLD_FRAMES)) begin
          m_state  = 1;
          m_frames = 0;
          m_score  = 0;
        end else if (i_animate && m_frames < 255) begin
          m_frames++;
        end
      end
      1: begin
        if (i_animate && (m_frames == GRACE_FRAMES - 1)) begin
          m_state  = 2;
          m_frames = 0;
          m_div    = 0;
        end else if (i_animate && m_frames < 255) begin
          m_frames++;
        end
      end
      default: begin
        if (hit_now) begin
          m_state  = 0;
          m_frames = 0;
          if (m_score > m_high) begin
            m_high     = m_score;
            m_new_high = 1;
          end
        end else if (i_animate) begin
          if (m_frames < 255) m_frames++;
          m_div++;
          if (m_div == SCORE_DIV) begin
            m_div   = 0;
            m_score = (m_score + 1) % 10000;
          end
        end
      end
    endcase
    start_hist[2] = start_hist[1];
    start_hist[1] = start_hist[0];
    start_hist[0] = i_start;
    coll_hist     = i_collision;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string name, input logic [1:0] st, input logic [15:0] sc,
                          input logic [15:0] hi, input logic nh);
    checkOutput({name, " state"}, {14'd0, o_game_state}, {14'd0, st});
    checkOutput({name, " score"}, o_score, sc);
    checkOutput({name, " high"}, o_high_score, hi);
    checkOutput({name, " new_high"}, {15'd0, o_new_high}, {15'd0, nh});
  endtask

  task automatic compareModel(input string name);
    checkAll({name, " model"}, 2'(m_state), to_bcd(m_score), to_bcd(m_high), m_new_high);
  endtask

  // Drive inputs, take one edge, advance the model, sample 1 ns later
  task automatic applyStimulus(input logic s, input logic c, input logic a);
    i_start     = s;
    i_collision = c;
    i_animate   = a;
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic applyPulses(input int n, input logic s, input logic c);
    for (int i = 0; i < n; i++) begin
      applyStimulus(s, c, 1'b1);
      applyStimulus(s, c, 1'b0);
    end
  endtask

  task automatic pressStart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        start;
    logic        coll;
    int          ncyc;
    int          npulse;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] hi;
    logic        nh;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3, 0,   2'b01, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1, 119, 2'b01, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 0, 1,   2'b10, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 0, 60,  2'b10, 16'h0010, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 0, 90,  2'b10, 16'h0025, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1, 0,   2'b10, 16'h0025, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1, 0,   2'b00, 16'h0025, 16'h0025, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1, 0,   2'b00, 16'h0025, 16'h0025, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 0, 30,  2'b00, 16'h0025, 16'h0025, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3, 0,   2'b00, 16'h0025, 16'h0025, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2, 30,  2'b00, 16'h0025, 16'h0025, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3, 0,   2'b01, 16'h0000, 16'h0025, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 0, 120, 2'b10, 16'h0000, 16'h0025, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 0, 150, 2'b10, 16'h0025, 16'h0025, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1, 0,   2'b10, 16'h0025, 16'h0025, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1, 0,   2'b00, 16'h0025, 16'h0025, 1'b0};

    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_collision = 1'b0;
    i_animate   = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    checkAll("reset", 2'b00, 16'h0000, 16'h0000, 1'b0);
    #1;
    i_rst = 1'b0;
    #1;

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < vecs[i].ncyc; k++) applyStimulus(vecs[i].start, vecs[i].coll, 1'b0);
      applyPulses(vecs[i].npulse, vecs[i].start, vecs[i].coll);
      checkAll($sformatf("vec%0d", i), vecs[i].st, vecs[i].sc, vecs[i].hi, vecs[i].nh);
      compareModel($sformatf("vec%0d", i));
    end

    // Hit and animate on the same edge: death wins, no score step
    applyPulses(60, 1'b0, 1'b0);
    pressStart();
    applyPulses(120, 1'b0, 1'b0);
    applyPulses(5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("hit_vs_animate", 2'b00, 16'h0000, 16'h0025, 1'b0);

    // Collision held through GRACE has no effect until PLAY begins
    applyPulses(60, 1'b0, 1'b0);
    i_collision = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyPulses(119, 1'b0, 1'b1);
    checkAll("grace_collide", 2'b01, 16'h0000, 16'h0025, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkAll("grace_to_play", 2'b10, 16'h0000, 16'h0025, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkAll("play_instant_death", 2'b00, 16'h0000, 16'h0025, 1'b0);

    // Long game through the 0999 -> 1000 carry chain
    applyPulses(60, 1'b0, 1'b0);
    pressStart();
    applyPulses(120, 1'b0, 1'b0);
    applyPulses(999 * SCORE_DIV, 1'b0, 1'b0);
    checkAll("score_0999", 2'b10, 16'h0999, 16'h0025, 1'b0);
    applyPulses(SCORE_DIV, 1'b0, 1'b0);
    checkAll("score_1000", 2'b10, 16'h1000, 16'h0025, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("high_1000", 2'b00, 16'h1000, 16'h1000, 1'b1);

    // Asynchronous reset mid-PLAY, observed before the next clock edge
    applyPulses(60, 1'b0, 1'b0);
    pressStart();
    applyPulses(120, 1'b0, 1'b0);
    applyPulses(40 * SCORE_DIV, 1'b0, 1'b0);
    checkAll("pre_reset", 2'b10, 16'h0040, 16'h1000, 1'b0);
    #2;
    i_rst = 1'b1;
    #1;
    checkAll("async_reset", 2'b00, 16'h0000, 16'h0000, 1'b0);
    model_reset();
    #2;
    i_rst = 1'b0;

    // Random play checked every cycle against the model
    begin
      logic s;
      s = 1'b0;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(0, 39) == 0) s = ~s;
        applyStimulus(s, 1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)));
        compareModel($sformatf("rand%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter GRACE_FRAMES, default 120: animate pulses spent in GRACE before PLAY (legal 1-255).
REQ-002 SHALL have parameter DEAD_HOLD_FRAMES, default 60: minimum animate pulses in DEAD before a restart is accepted (legal 0-255).
REQ-003 SHALL have parameter SCORE_DIV, default 6: animate pulses in PLAY per score increment (legal 1-255).
REQ-004 SHALL have ports: i_clk  in  1  system clock, 100 MHz.
REQ-005 SHALL have ports: i_rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports: i_animate  in  1  one-cycle end-of-frame tick, synchronous to i_clk.
REQ-007 SHALL have ports: i_collision  in  1  dino/obstacle overlap, synchronous to i_clk, may toggle every pixel.
REQ-008 SHALL have ports: i_start  in  1  raw jump button, asynchronous.
REQ-009 SHALL have ports: o_game_state  out  2  DEAD=2'b00, GRACE=2'b01, PLAY=2'b10; 2'b11 never driven.
REQ-010 SHALL have ports: o_score  out  16  current score, 4 BCD digits.
REQ-011 SHALL have ports: o_high_score  out  16  best score since reset, 4 BCD digits.
REQ-012 SHALL have ports: o_new_high  out  1  one-cycle pulse when o_high_score is updated.

Function
REQ-013 SHALL pass i_start through a 2-flop synchronizer, then rising-edge detect; a "press" is that edge (3rd i_clk edge after i_start rises).
REQ-014 SHALL register i_collision once; a "hit" is the registered value high while state is PLAY.
REQ-015 SHALL keep an 8-bit frame counter, cleared on every state change, incremented on i_animate, saturating at 255.
REQ-016 DEAD: press with frame counter >= DEAD_HOLD_FRAMES -> GRACE; earlier presses SHALL be discarded, not queued.
REQ-017 GRACE: i_animate with frame counter == GRACE_FRAMES-1 -> PLAY; hits and presses ignored.
REQ-018 PLAY: hit -> DEAD on the next i_clk edge (o_game_state = DEAD two edges after i_collision sampled high).
REQ-019 On DEAD->GRACE, o_score SHALL clear to 0000 in the same cycle as the state change.
REQ-020 In PLAY a divider SHALL count i_animate pulses; on reaching SCORE_DIV it resets to 0 and o_score increments by 1 in BCD.
REQ-021 BCD increment SHALL carry per digit (x9 -> (x+1)0); 9999 wraps to 0000 with no flag.
REQ-022 Divider SHALL clear on entry to PLAY; score does not advance in GRACE or DEAD.
REQ-023 Hit and i_animate in the same cycle: transition to DEAD wins, no score increment.
REQ-024 On PLAY->DEAD, if o_score > o_high_score (BCD compare) then o_high_score <= o_score one cycle later and o_new_high pulses high for exactly that cycle.
REQ-025 Equal score SHALL NOT update o_high_score nor pulse o_new_high.
REQ-026 i_start held high continuously SHALL generate only one press.

Reset
REQ-027 i_rst high SHALL immediately force: state DEAD, frame counter 255 (restart allowed at once), divider 0, o_score 0000, o_high_score 0000, o_new_high 0, synchronizer flops 0.
REQ-028 Reset asserted mid-PLAY SHALL discard the score without updating o_high_score.
REQ-029 First press after reset deassertion SHALL be accepted regardless of DEAD_HOLD_FRAMES.

Verification
REQ-030 Reset, press i_start -> o_game_state 01 after 3 edges; after 120 i_animate pulses -> 10.
REQ-031 In PLAY, 60 i_animate pulses (SCORE_DIV=6) -> o_score 0010; preload 0999 path: 6 more pulses from 0999 -> 1000.
REQ-032 i_collision high 1 cycle in PLAY with score 0025, high 0000 -> state 00 two edges later, o_high_score 0025, o_new_high single pulse.
REQ-033 i_collision held high throughout GRACE -> state stays 01, reaches 10 on schedule, then goes 00 immediately after.
REQ-034 In DEAD, press after 30 frames -> ignored; release, press after 60 frames -> 01, o_score 0000, o_high_score unchanged.
REQ-035 Assert i_rst asynchronously mid-PLAY at score 0040 -> outputs 00/0000/0000 without waiting for an i_clk edge.
